tensor_ram_loader: RTL and testbench
====================================

# tensor_ram_loader

Upstream stage of `tensor_ram`. Accepts a stream of 8-bit pixels over a valid/ready handshake and packs them little-endian into `D_WIDTH`-bit words. Issues one `tensor_ram` write per packed word at consecutive addresses from a programmable base. Used to load input feature maps and layer outputs into tensor storage before the compute array reads them.

## Interface
- `D_WIDTH`, 32: RAM word width; must be a multiple of `PIXEL_WIDTH`.
- `PIXEL_WIDTH`, 8: width of one pixel.
- `DEPTH`, 96*96: RAM depth in words.
- `PPW` (localparam), `D_WIDTH/PIXEL_WIDTH` = 4: pixels per word.
- `ADDR_W` (localparam), `$clog2(DEPTH)`: address width.
- `NP_W` (localparam), `$clog2(DEPTH*PPW+1)`: pixel-count width.

Ports:
- `clk` in 1: the single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a transfer. Sampled only in IDLE.
- `base_addr` in ADDR_W: first word address. Sampled with `start`.
- `num_pixels` in NP_W: pixels in the transfer. Sampled with `start`.
- `in_valid` in 1: `in_pixel` holds valid data.
- `in_ready` out 1: loader can accept a pixel this cycle.
- `in_pixel` in PIXEL_WIDTH: pixel data.
- `we` out 1: RAM write enable. Connects to `tensor_ram.we`.
- `addr_w` out ADDR_W: RAM write address.
- `din` out D_WIDTH: RAM write data.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle pulse when a transfer completes.

## Operation
- States: IDLE, FILL.
- IDLE with `start`=1:
  - Latch `base_addr` into the address counter and `num_pixels` into the remaining count. Clear the lane index and the pack register.
  - If `num_pixels`≠0, go to FILL.
  - If `num_pixels`=0, pulse `done` next cycle, stay in IDLE, issue no write.
- IDLE ignores `in_valid`. `start` while in FILL is ignored.
- FILL:
  - `in_ready` = 1 while the remaining count > 0. `in_ready` is a registered output.
  - A pixel is accepted on any cycle with `in_valid && in_ready`.
  - An accepted pixel is placed in lane `k`, bits [PIXEL_WIDTH*k +: PIXEL_WIDTH], where `k` is the lane index 0..PPW-1. The lane index then increments. The remaining count decrements.
- A word is complete when lane PPW-1 is filled, or when the last pixel of the transfer is accepted.
  - Lanes not filled in a final partial word are zero.
  - The complete word is written out and the lane index resets to 0.
  - The address counter increments by 1, wrapping from DEPTH-1 to 0.
- When the last pixel of the transfer has been accepted, `in_ready` drops. The final write is issued, `done` pulses, and the FSM returns to IDLE.
- Pixel ordering is strict arrival order. There is no reordering or dropping.
- Reset, at any time including mid-transfer:
  - Go to IDLE.
  - Discard the partial word. No write is issued for it.
  - All outputs take their reset values on the next edge.

## Timing
- Reset values: `in_ready`=0, `we`=0, `addr_w`=0, `din`=0, `busy`=0, `done`=0.
- `start` sampled at edge T0: `busy`=1 and `in_ready`=1 from T0+1. With `num_pixels`=0, `done`=1 at T0+1 and `busy` stays 0.
- Pixel that completes a word accepted at edge T: `we`=1 with the corresponding `addr_w`/`din` during cycle T+1, for exactly one cycle. `we`, `addr_w` and `din` are all registered outputs.
- Full-rate input of one pixel per cycle gives one write every PPW cycles.
- Final pixel accepted at edge T:
  - `in_ready`=0 from T+1.
  - Final `we`=1 and `done`=1 together in cycle T+1.
  - `busy`=0 from T+2.
  - Earliest next `start` is sampled at edge T+2.
- `addr_w` and `din` hold their last value when `we`=0.
- Gaps in `in_valid` stall packing with no state loss.
- Write data is visible to `tensor_ram` reads according to that block's write-first rule.

## Test plan
- Basic packing: base 0, num_pixels 8, pixels 0x01..0x08 at full rate.
  - Expect writes addr 0 = 0x04030201, then addr 1 = 0x08070605, 4 cycles apart.
  - Expect `done` in the same cycle as the second write.
- Partial final word: base 10, 6 pixels 0xA1..0xA6.
  - Expect addr 10 = 0xA4A3A2A1 and addr 11 = 0x0000A6A5.
  - Expect exactly 2 writes.
- Backpressure: random `in_valid` gaps over 32 pixels.
  - Expect 8 writes, data and address sequence identical to the full-rate run.
  - `in_ready` never asserts outside FILL.
- Address wrap: base DEPTH-1, 8 pixels.
  - Expect writes at addr DEPTH-1, then addr 0.
- Zero-length and ignored start: `num_pixels`=0.
  - Expect a `done` pulse at T0+1 and no `we`.
  - A `start` pulsed during FILL of an active transfer changes neither the address nor the count.
- Reset mid-transfer: assert `reset` after 6 of 8 pixels (one word already written).
  - Expect no second write and all outputs at reset values.
  - A new transfer afterwards starts at its own `base_addr` at lane 0.

Source files
------------

// File: rtl/tensor_ram_loader.sv
// Packs a valid/ready stream of pixels little-endian into RAM words and writes them at consecutive,
// wrapping addresses from a programmable base. Each write is registered and appears one cycle after the completing pixel.
module tensor_ram_loader #(
  parameter  int D_WIDTH     = 32,
  parameter  int PIXEL_WIDTH = 8,
  parameter  int DEPTH       = 96*96,
  localparam int PPW         = D_WIDTH / PIXEL_WIDTH,
  localparam int ADDR_W      = $clog2(DEPTH),
  localparam int NP_W        = $clog2(DEPTH*PPW + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [NP_W-1:0]        num_pixels,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  output logic                   we,
  output logic [ADDR_W-1:0]      addr_w,
  output logic [D_WIDTH-1:0]     din,
  output logic                   busy,
  output logic                   done
);

  localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NP_W-1:0]     rem_q, rem_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [D_WIDTH-1:0]  pack_q, pack_d;
  logic                in_ready_q, in_ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_w_q, addr_w_d;
  logic [D_WIDTH-1:0]  din_q, din_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [D_WIDTH-1:0]  pack_ins;
  logic                accept;
  logic                last_px;
  logic                word_end;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    lane_d   = lane_q;
    pack_d   = pack_q;
    we_d     = 1'b0;
    addr_w_d = addr_w_q;
    din_d    = din_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    pack_ins = pack_q;
    pack_ins[lane_q*PIXEL_WIDTH +: PIXEL_WIDTH] = in_pixel;

    accept   = in_valid && in_ready_q;
    last_px  = (rem_q == NP_W'(1));
    word_end = (lane_q == LANE_W'(PPW-1)) || last_px;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = base_addr;
          rem_d  = num_pixels;
          lane_d = '0;
          pack_d = '0;
          if (num_pixels != '0) begin
            state_d = S_FILL;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      S_FILL: begin
        // Count exhausted: this is the cycle showing the final write and done; busy drops after it.
        if (rem_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (accept) begin
          rem_d = rem_q - NP_W'(1);
          if (word_end) begin
            we_d     = 1'b1;
            addr_w_d = addr_q;
            din_d    = pack_ins;
            addr_d   = (addr_q == ADDR_W'(DEPTH-1)) ? '0 : addr_q + ADDR_W'(1);
            lane_d   = '0;
            pack_d   = '0;
            done_d   = last_px;
          end else begin
            pack_d = pack_ins;
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_FILL) && (rem_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      lane_q     <= '0;
      pack_q     <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_w_q   <= '0;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      lane_q     <= lane_d;
      pack_q     <= pack_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_w_q   <= addr_w_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign we       = we_q;
  assign addr_w   = addr_w_q;
  assign din      = din_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tensor_ram_loader.sv
// Bench for tensor_ram_loader: drives pixel transfers and compares the observed RAM writes
// against expected words built directly from the pixel list, base address and wrap rule.
module tb_tensor_ram_loader;

  localparam int D_WIDTH     = 32;
  localparam int PIXEL_WIDTH = 8;
  localparam int DEPTH       = 96*96;
  localparam int PPW         = D_WIDTH / PIXEL_WIDTH;
  localparam int ADDR_W      = $clog2(DEPTH);
  localparam int NP_W        = $clog2(DEPTH*PPW + 1);

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic [ADDR_W-1:0]      base_addr = '0;
  logic [NP_W-1:0]        num_pixels = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [PIXEL_WIDTH-1:0] in_pixel = '0;
  logic                   we;
  logic [ADDR_W-1:0]      addr_w;
  logic [D_WIDTH-1:0]     din;
  logic                   busy;
  logic                   done;

  tensor_ram_loader #(.D_WIDTH(D_WIDTH), .PIXEL_WIDTH(PIXEL_WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_pixels(num_pixels),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .we(we), .addr_w(addr_w), .din(din), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] pix[$];
  int         exp_addr[$];
  logic [31:0] exp_dat[$];
  int         got_addr[$];
  logic [31:0] got_dat[$];
  int         got_cyc[$];
  int         done_cnt = 0;
  int         bad_ready = 0;
  int         cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (we) begin
      got_addr.push_back(int'(addr_w));
      got_dat.push_back(din);
      got_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
    if (in_ready && !busy) bad_ready++;
  end

  // Expected writes: groups of PPW pixels, lowest pixel in the low byte, short last word zero-filled.
  function automatic void build_model(input int base, input int n);
    exp_addr.delete();
    exp_dat.delete();
    for (int w = 0; w * PPW < n; w++) begin
      logic [31:0] d = '0;
      for (int j = 0; j < PPW; j++)
        if (w * PPW + j < n) d = d | (32'(pix[w*PPW + j]) << (8 * j));
      exp_addr.push_back((base + w) % DEPTH);
      exp_dat.push_back(d);
    end
  endfunction

  function automatic void clear_obs();
    got_addr.delete();
    got_dat.delete();
    got_cyc.delete();
    done_cnt = 0;
  endfunction

  task automatic do_start(input int base, input int n);
    @(negedge clk);
    start = 1'b1;
    base_addr = ADDR_W'(base);
    num_pixels = NP_W'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive(input int n, input bit gaps, input bit inject);
    int idx = 0;
    int guard = 0;
    bit acc;
    bit injected = 1'b0;
    while (idx < n && guard < 2000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_pixel = pix[idx];
      if (inject && idx == 2 && !injected) begin
        start = 1'b1; base_addr = ADDR_W'(500); num_pixels = NP_W'(3); injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    vectors++;
    if (idx != n) begin
      miscompares++;
      $display("FAIL drive_timeout: accepted %0d pixels, required %0d", idx, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 6;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    if (we !== 1'b0)       begin miscompares++; $display("FAIL reset_we: got %b want 0", we); end
    if (addr_w !== '0)     begin miscompares++; $display("FAIL reset_addr_w: got %0d want 0", addr_w); end
    if (din !== '0)        begin miscompares++; $display("FAIL reset_din: got %h want 0", din); end
    if (busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0)     begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_packing();
    pix.delete();
    for (int i = 1; i <= 8; i++) pix.push_back(8'(i));
    clear_obs();
    do_start(0, 8);
    vectors += 2;
    if (busy !== 1'b1)     begin miscompares++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_rise: got %b want 1", in_ready); end
    drive(8, 1'b0, 1'b0);
    vectors += 3;
    if (we !== 1'b1)       begin miscompares++; $display("FAIL basic_final_we: got %b want 1", we); end
    if (done !== 1'b1)     begin miscompares++; $display("FAIL basic_done_with_we: got %b want 1", done); end
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_drop: got %b want 0", in_ready); end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0)     begin miscompares++; $display("FAIL basic_busy_fall: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    vectors += 2;
    if (got_addr.size() != 2) begin
      miscompares++; $display("FAIL basic_write_count: got %0d want 2", got_addr.size());
    end else begin
      vectors += 5;
      if (got_addr[0] != 0)           begin miscompares++; $display("FAIL basic_addr0: got %0d want 0", got_addr[0]); end
      if (got_dat[0] !== 32'h04030201) begin miscompares++; $display("FAIL basic_dat0: got %h want 04030201", got_dat[0]); end
      if (got_addr[1] != 1)           begin miscompares++; $display("FAIL basic_addr1: got %0d want 1", got_addr[1]); end
      if (got_dat[1] !== 32'h08070605) begin miscompares++; $display("FAIL basic_dat1: got %h want 08070605", got_dat[1]); end
      if (got_cyc[1] - got_cyc[0] != 4) begin miscompares++; $display("FAIL basic_spacing: got %0d want 4", got_cyc[1] - got_cyc[0]); end
    end
    if (done_cnt != 1) begin miscompares++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_partial_word();
    pix.delete();
    for (int i = 0; i < 6; i++) pix.push_back(8'hA1 + 8'(i));
    clear_obs();
    do_start(10, 6);
    drive(6, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    vectors++;
    if (got_addr.size() != 2) begin
      miscompares++; $display("FAIL partial_write_count: got %0d want 2", got_addr.size());
    end else begin
      vectors += 4;
      if (got_addr[0] != 10)           begin miscompares++; $display("FAIL partial_addr0: got %0d want 10", got_addr[0]); end
      if (got_dat[0] !== 32'hA4A3A2A1) begin miscompares++; $display("FAIL partial_dat0: got %h want a4a3a2a1", got_dat[0]); end
      if (got_addr[1] != 11)           begin miscompares++; $display("FAIL partial_addr1: got %0d want 11", got_addr[1]); end
      if (got_dat[1] !== 32'h0000A6A5) begin miscompares++; $display("FAIL partial_dat1: got %h want 0000a6a5", got_dat[1]); end
    end
  endtask

  task automatic test_backpressure();
    pix.delete();
    for (int i = 0; i < 32; i++) pix.push_back(8'($urandom));
    build_model(0, 32);
    clear_obs();
    bad_ready = 0;
    do_start(0, 32);
    drive(32, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    vectors += 3;
    if (got_addr.size() != exp_addr.size()) begin
      miscompares++; $display("FAIL bp_write_count: got %0d want %0d", got_addr.size(), exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        vectors++;
        if (got_addr[i] != exp_addr[i] || got_dat[i] !== exp_dat[i]) begin
          miscompares++;
          $display("FAIL bp_write%0d: got %0d/%h want %0d/%h", i, got_addr[i], got_dat[i], exp_addr[i], exp_dat[i]);
        end
      end
    end
    if (done_cnt != 1)  begin miscompares++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
    if (bad_ready != 0) begin miscompares++; $display("FAIL bp_ready_outside_fill: got %0d cycles want 0", bad_ready); end
  endtask

  task automatic test_addr_wrap();
    pix.delete();
    for (int i = 0; i < 8; i++) pix.push_back(8'($urandom));
    build_model(DEPTH-1, 8);
    clear_obs();
    do_start(DEPTH-1, 8);
    drive(8, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    vectors++;
    if (got_addr.size() != 2) begin
      miscompares++; $display("FAIL wrap_write_count: got %0d want 2", got_addr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got_addr[i] != exp_addr[i] || got_dat[i] !== exp_dat[i]) begin
          miscompares++;
          $display("FAIL wrap_write%0d: got %0d/%h want %0d/%h", i, got_addr[i], got_dat[i], exp_addr[i], exp_dat[i]);
        end
      end
    end
  endtask

  task automatic test_zero_and_ignored_start();
    clear_obs();
    do_start(77, 0);
    vectors += 3;
    if (done !== 1'b1)     begin miscompares++; $display("FAIL zero_done: got %b want 1", done); end
    if (busy !== 1'b0)     begin miscompares++; $display("FAIL zero_busy: got %b want 0", busy); end
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL zero_ready: got %b want 0", in_ready); end
    repeat (3) @(negedge clk);
    vectors++;
    if (got_addr.size() != 0) begin miscompares++; $display("FAIL zero_no_write: got %0d writes want 0", got_addr.size()); end

    pix.delete();
    for (int i = 0; i < 8; i++) pix.push_back(8'($urandom));
    build_model(100, 8);
    clear_obs();
    do_start(100, 8);
    drive(8, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    vectors += 2;
    if (got_addr.size() != 2) begin
      miscompares++; $display("FAIL ignstart_write_count: got %0d want 2", got_addr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got_addr[i] != exp_addr[i] || got_dat[i] !== exp_dat[i]) begin
          miscompares++;
          $display("FAIL ignstart_write%0d: got %0d/%h want %0d/%h", i, got_addr[i], got_dat[i], exp_addr[i], exp_dat[i]);
        end
      end
    end
    if (done_cnt != 1) begin miscompares++; $display("FAIL ignstart_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_transfer();
    pix.delete();
    for (int i = 0; i < 8; i++) pix.push_back(8'($urandom));
    build_model(20, 8);
    clear_obs();
    do_start(20, 8);
    drive(6, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors += 6;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
    if (we !== 1'b0)       begin miscompares++; $display("FAIL midrst_we: got %b want 0", we); end
    if (addr_w !== '0)     begin miscompares++; $display("FAIL midrst_addr_w: got %0d want 0", addr_w); end
    if (din !== '0)        begin miscompares++; $display("FAIL midrst_din: got %h want 0", din); end
    if (busy !== 1'b0)     begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (done !== 1'b0)     begin miscompares++; $display("FAIL midrst_done: got %b want 0", done); end
    repeat (4) @(negedge clk);
    vectors++;
    if (got_addr.size() != 1) begin
      miscompares++; $display("FAIL midrst_write_count: got %0d want 1", got_addr.size());
    end else begin
      vectors++;
      if (got_addr[0] != exp_addr[0] || got_dat[0] !== exp_dat[0]) begin
        miscompares++;
        $display("FAIL midrst_write0: got %0d/%h want %0d/%h", got_addr[0], got_dat[0], exp_addr[0], exp_dat[0]);
      end
    end

    pix.delete();
    for (int i = 0; i < 4; i++) pix.push_back(8'($urandom));
    build_model(40, 4);
    clear_obs();
    do_start(40, 4);
    drive(4, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    vectors++;
    if (got_addr.size() != 1) begin
      miscompares++; $display("FAIL postrst_write_count: got %0d want 1", got_addr.size());
    end else begin
      vectors++;
      if (got_addr[0] != exp_addr[0] || got_dat[0] !== exp_dat[0]) begin
        miscompares++;
        $display("FAIL postrst_write0: got %0d/%h want %0d/%h", got_addr[0], got_dat[0], exp_addr[0], exp_dat[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_packing();
    test_partial_word();
    test_backpressure();
    test_addr_wrap();
    test_zero_and_ignored_start();
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
